cla_seq_ctrl: RTL and testbench

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

---
 rtl/cla_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_cla_seq_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cla_seq_ctrl
//
// Purpose:
//   Sequences a WIDTH-bit addition through an external combinational 4-bit
//   carry-lookahead adder, one nibble per clock. Each accepted operand set
//   takes WIDTH/4 cycles in RUN. The result is then presented in DONE until
//   the consumer takes it.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake (accepted only in IDLE)
//   a, b, cin           WIDTH-bit addends and carry-in
//   cla_a, cla_b        nibble operands to the external CLA (0 outside RUN)
//   cla_cin             carry into the external CLA (0 outside RUN)
//   cla_sum, cla_cout   combinational response of the external CLA
//   out_valid,out_ready result handshake (out_valid high in DONE)
//   sum, cout, ovf      result, carry-out and signed overflow
//   busy                high in RUN and DONE
// ---------------------------------------------------------------------------
module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IDX_W-1:0] idx_reg;

  logic             accept;
  logic             run;
  logic             last;
  logic [3:0]       a_nib [NIB];
  logic [3:0]       b_nib [NIB];
  logic [NIB-1:0]   nib_sel;

  assign accept = (state_reg == IDLE) && in_valid;
  assign run    = (state_reg == RUN);
  assign last   = run && (idx_reg == LAST_IDX);

  // Per-nibble views of the captured operands and the next result value.
  // A nibble of the result is cleared on acceptance and written exactly once,
  // in the RUN cycle whose index selects it.
  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi]   = a_reg[4*gi +: 4];
      assign b_nib[gi]   = b_reg[4*gi +: 4];
      assign nib_sel[gi] = (idx_reg == IDX_W'(gi));
      assign sum_next[4*gi +: 4] = accept                 ? 4'h0    :
                                   (run && nib_sel[gi])   ? cla_sum :
                                                            sum_reg[4*gi +: 4];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, ripple of the carry between nibble steps,
  // and the final carry-out / overflow capture on the last RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      sum_reg <= sum_next;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        cout_reg  <= 1'b0;
        ovf_reg   <= 1'b0;
        idx_reg   <= '0;
      end else if (run) begin
        carry_reg <= cla_cout;
        if (last) begin
          cout_reg <= cla_cout;
          // cla_sum[3] is the MSB of the full result on the last step
          ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                      (cla_sum[3] != a_reg[WIDTH-1]);
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  // Outputs. CLA drives are gated by state so they drop to zero as soon as
  // reset forces IDLE, without waiting for a clock.
  assign cla_a     = run ? a_nib[idx_reg] : 4'h0;
  assign cla_b     = run ? b_nib[idx_reg] : 4'h0;
  assign cla_cin   = run & carry_reg;
  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_ctrl
//
// Purpose:
//   Directed self-checking bench for cla_seq_ctrl (WIDTH=16). A behavioural
//   4-bit adder stands in for the external CLA. Each scenario task drives
//   its own stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cla_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;

  logic         in_ready;
  logic [3:0]   cla_a, cla_b, cla_sum;
  logic         cla_cin, cla_cout;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // External 4-bit adder model
  assign {cla_cout, cla_sum} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

  cla_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .cla_a     (cla_a),
    .cla_b     (cla_b),
    .cla_cin   (cla_cin),
    .cla_sum   (cla_sum),
    .cla_cout  (cla_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE. Operands are scrambled right after
  // acceptance so any late sampling by the DUT shows up in the result.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic oc, output logic [W-1:0] s,
                       output logic co, output logic ov, output int lat,
                       output logic [3:0] cseq);
    in_valid = 1'b1; a = oa; b = ob; cin = oc;
    tick();
    in_valid = 1'b0; a = ~oa; b = ~ob; cin = ~oc;
    lat  = -1;
    cseq = 4'h0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) begin
        lat = n;
        break;
      end
      if (n < 4) cseq[n] = cla_cin;
      tick();
    end
    s = sum; co = cout; ov = ovf;
    $display("[TB] op a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             oa, ob, oc, s, co, ov, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_flags: got in_ready/busy/out_valid=%b want 100",
               {in_ready, busy, out_valid});
    end
    tests_run++;
    if ({sum, cout, ovf, cla_a, cla_b, cla_cin} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b cla_a=%h cla_b=%h cla_cin=%b want all 0",
               sum, cout, ovf, cla_a, cla_b, cla_cin);
    end
    tick();
    rst_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] s; logic co, ov; int lat; logic [3:0] cseq;
    do_op(16'h0FFF, 16'h0001, 1'b0, s, co, ov, lat, cseq);
    tests_run++;
    if ({s, co, ov} !== {16'h1000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL carry_chain_result: got sum=%h cout=%b ovf=%b want 1000 0 0", s, co, ov);
    end
    tests_run++;
    if (cseq !== 4'b1110) begin
      tests_failed++;
      $display("FAIL carry_chain_cla_cin: got seq(i3..i0)=%b want 1110", cseq);
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL latency: got %0d edges want 4", lat);
    end
  endtask

  task automatic test_cin_wrap();
    logic [W-1:0] s; logic co, ov; int lat; logic [3:0] cseq;
    do_op(16'hFFFF, 16'h0000, 1'b1, s, co, ov, lat, cseq);
    tests_run++;
    if ({s, co, ov} !== {16'h0000, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL cin_wrap: got sum=%h cout=%b ovf=%b want 0000 1 0", s, co, ov);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s; logic co, ov; int lat; logic [3:0] cseq;
    do_op(16'h7FFF, 16'h0001, 1'b0, s, co, ov, lat, cseq);
    tests_run++;
    if ({s, co, ov} !== {16'h8000, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL overflow: got sum=%h cout=%b ovf=%b want 8000 0 1", s, co, ov);
    end
  endtask

  task automatic test_hold();
    bit seen;
    // 8001+8001 = 1_0002, both operands negative, result positive
    in_valid = 1'b1; a = 16'h8001; b = 16'h8001; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin seen = 1'b1; break; end
      tick();
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL hold_done_timeout: got out_valid=0 want 1 within 10 cycles");
    end
    a = 16'h1111; b = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      tests_run++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0002, 1'b1, 1'b1}) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b want 1 0 0002 1 1",
                 i, out_valid, in_ready, sum, cout, ovf);
      end
    end
    $display("[TB] held DONE 5 cycles sum=%h", sum);
    // in_valid stays high through the DONE exit edge and must not be taken
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if ({busy, in_ready, out_valid, sum, cout, ovf} !== {1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL hold_exit: got busy=%b in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b want 0 1 0 0002 1 1",
               busy, in_ready, out_valid, sum, cout, ovf);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({busy, sum} !== {1'b1, 16'h0000}) begin
      tests_failed++;
      $display("FAIL hold_reaccept: got busy=%b sum=%h want 1 0000", busy, sum);
    end
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin seen = 1'b1; break; end
      tick();
    end
    tests_run++;
    if (!seen || sum !== 16'h3333) begin
      tests_failed++;
      $display("FAIL hold_next_op: got out_valid=%b sum=%h want 1 3333", seen, sum);
    end
    $display("[TB] op a=1111 b=2222 cin=0 -> sum=%h", sum);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic co, ov; int lat; logic [3:0] cseq;
    bit spurious;
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({busy, cla_a, cla_b, cla_cin} !== {1'b1, 4'hF, 4'hF, 1'b1}) begin
      tests_failed++;
      $display("FAIL run_idx2: got busy=%b cla_a=%h cla_b=%h cla_cin=%b want 1 f f 1",
               busy, cla_a, cla_b, cla_cin);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, busy, out_valid, cla_a, cla_b, cla_cin, sum, cout, ovf} !==
        {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: got in_ready=%b busy=%b out_valid=%b cla_a=%h cla_b=%h cla_cin=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0 0 0000 0 0",
               in_ready, busy, out_valid, cla_a, cla_b, cla_cin, sum, cout, ovf);
    end
    tick();
    rst_n = 1'b1;
    $display("[TB] reset pulsed during RUN");
    spurious = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (out_valid || busy) spurious = 1'b1;
      tick();
    end
    tests_run++;
    if (spurious) begin
      tests_failed++;
      $display("FAIL reset_discard: got out_valid/busy after reset want none");
    end
    do_op(16'h1234, 16'h4321, 1'b0, s, co, ov, lat, cseq);
    tests_run++;
    if ({s, co, ov} !== {16'h5555, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL post_reset_op: got sum=%h cout=%b ovf=%b want 5555 0 0", s, co, ov);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
  } op_t;

  task automatic test_back_to_back();
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    op_t          q [$];
    op_t          e;
    logic [W:0]   ref_full;
    logic         ref_ovf;
    int           prev;
    int           nres;
    ta = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hABCD, 16'h1357, 16'h0F0F, 16'hC3A5};
    tb = '{16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000, 16'h5432, 16'h2468, 16'hF0F1, 16'h3C5B};
    prev = -1;
    nres = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        nres++;
        if (q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL b2b_spurious: got out_valid at cycle %0d want no result pending", c);
        end else begin
          e = q.pop_front();
          ref_full = 17'(e.a) + 17'(e.b) + 17'(e.c);
          ref_ovf  = (e.a[W-1] == e.b[W-1]) && (ref_full[W-1] != e.a[W-1]);
          $display("[TB] b2b a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d at cycle %0d",
                   e.a, e.b, e.c, sum, cout, ovf, c);
          tests_run++;
          if ({sum, cout, ovf} !== {ref_full[W-1:0], ref_full[W], ref_ovf}) begin
            tests_failed++;
            $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b want %h %b %b",
                     sum, cout, ovf, ref_full[W-1:0], ref_full[W], ref_ovf);
          end
        end
        if (prev >= 0) begin
          tests_run++;
          if (c - prev !== 6) begin
            tests_failed++;
            $display("FAIL b2b_interval: got %0d cycles want 6", c - prev);
          end
        end
        prev = c;
      end
      a   = ta[c % 8];
      b   = tb[c % 8];
      cin = c[0];
      if (in_ready) q.push_back('{a: a, b: b, c: cin});
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (nres !== 6) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d results want 6", nres);
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_cin_wrap();
    test_overflow();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
